gppcu_pipe_ctrl: RTL and testbench
==================================

Name: gppcu_pipe_ctrl

Overview:
- Instruction sequencer and control-word pipeline that sits directly upstream of every GPPCU thread.
- Fetches instructions from the shared instruction memory and obtains each control word from an external combinational decoder.
- Shifts instruction/control-word pairs through the FCH/DEC/EXEC/WB stages and drives them in common to all threads.
- Stalls on the ORed thread busy signal (multi-cycle FPU); runs one kernel per start/done handshake.

Parameters:
- DBW, 32, instruction width.
- IABW, 10, instruction memory address width.
- CW_BITS, 16, control word width; bit 0 is the stage-valid bit.
- OPC_LSB, 26, LSB of the 6-bit opcode field in the instruction.
- HALT_OPC, 6'h3F, opcode that ends the kernel.

Ports:
- iACLK  in  1  clock.
- iARESETn  in  1  synchronous active-low reset.
- iSTART  in  1  start pulse; honoured only in IDLE.
- iSTART_PC  in  IABW  first instruction address.
- oIDLE  out  1  high in IDLE.
- oDONE  out  1  one-cycle pulse at kernel end.
- oIMEM_ADDR  out  IABW  instruction memory read address (registered PC).
- oIMEM_RDEN  out  1  read enable; rdata is valid 1 cycle after an enabled read.
- iIMEM_RDATA  in  DBW  instruction memory read data.
- oDEC_INSTR  out  DBW  equals oINSTR_DEC; feeds the external decoder.
- iDEC_CW  in  CW_BITS  decoder output, combinational from oDEC_INSTR.
- iBUSY  in  1  OR of all thread busy outputs.
- oINSTR_FCH, oINSTR_DEC, oINSTR_EXEC, oINSTR_WB  out  DBW  per-stage instruction.
- oCW_DEC, oCW_EXEC, oCW_WB  out  CW_BITS  per-stage control word; bit 0 = stage valid.

Behaviour:
- Clock and reset: single clock iACLK; reset iARESETn is synchronous, active-low.
- Reset state: IDLE; PC=0; all stage valid bits 0; all instruction/CW outputs 0; oDONE=0; oIMEM_RDEN=0; oIDLE=1.
- Reset applied mid-kernel aborts the kernel immediately: no oDONE pulse, all stages are emptied.
- Control states are IDLE, RUN, DRAIN and DONE.
- IDLE: when iSTART=1, load PC<=iSTART_PC and go to RUN. iSTART is ignored in any other state.
- RUN: while not stalled, oIMEM_RDEN=1 and PC increments by 1 each cycle.
  - PC wraps from 2^IABW-1 to 0.
  - The FCH stage captures iIMEM_RDATA one cycle after each enabled read.
- Pipeline advance (no stall): FCH->DEC->EXEC->WB.
  - oCW_DEC is iDEC_CW with bit 0 forced to the DEC valid bit.
  - The EXEC and WB stages register the previous stage's instruction and CW.
- Stall: while iBUSY=1, hold PC, FCH, DEC and EXEC; oIMEM_RDEN=0, so memory data is held.
  - WB receives a bubble: oCW_WB[0]=0, instruction held.
  - When iBUSY falls, advance resumes that same cycle with nothing lost or duplicated.
- HALT: when an advancing DEC stage holds opcode==HALT_OPC:
  - HALT is not passed to EXEC; a bubble is passed instead.
  - The FCH stage and any in-flight read are squashed.
  - PC freezes and the state goes to DRAIN.
  - A HALT sitting in DEC during a stall takes effect only when the stall releases.
- DRAIN: go to DONE on the first cycle in which the EXEC and WB valid bits are both 0. iBUSY is still honoured.
- DONE: oDONE=1 for exactly one cycle, then IDLE.
- Latency from iSTART sampled at t0:
  - PC=iSTART_PC and read issued at t1.
  - Instruction in FCH at t2, DEC at t3, EXEC at t4, WB at t5.
- Invalid stages carry CW bit 0 = 0; the other fields are don't-care but never X after reset.

Optional Feature:
- Macro: GPPCU_PIPE_PERF_EN.
- Defined: adds outputs oPERF_CYCLES[31:0] and oPERF_STALLS[31:0].
  - Both clear on the iSTART acceptance.
  - oPERF_CYCLES counts every cycle in RUN or DRAIN.
  - oPERF_STALLS counts those cycles that also have iBUSY=1.
  - Both saturate at 32'hFFFFFFFF and hold their values in IDLE.
  - Reset value 0.
- Undefined: ports and counters are absent; no other behaviour change.

Test Plan:
- Reset: hold iARESETn=0 for 3 cycles with iSTART=1 -> oIDLE=1, all CW valid bits 0, oIMEM_RDEN=0, oDONE never asserted.
- Single HALT at address 0x000, iSTART_PC=0 at t0 -> read at t1, HALT in DEC at t3, nothing reaches EXEC/WB, oDONE=1 at t5 only.
- Three NOPs at 0x010-0x012 then HALT at 0x013, start at 0x010:
  - WB valid at t5, t6, t7 in address order.
  - oDONE=1 at t9.
  - Instruction at 0x014 never valid in DEC.
- iBUSY=1 for 4 cycles while the second instruction is in EXEC:
  - oINSTR_EXEC held.
  - oCW_WB[0]=0 for those 4 cycles.
  - Instruction sequence in WB unchanged.
  - oDONE delayed by exactly 4 cycles.
- Start at PC=0x3FF with IABW=10 -> oIMEM_ADDR sequence 0x3FF, 0x000, 0x001; iSTART pulsed during RUN is ignored.
- With GPPCU_PIPE_PERF_EN, third scenario plus the 4-cycle stall -> oPERF_STALLS=4 and oPERF_CYCLES=12 at oDONE.

Source files
------------

// File: rtl/gppcu_pipe_ctrl.sv
// Instruction sequencer and FCH/DEC/EXEC/WB control-word pipeline shared by all GPPCU threads.
// Optional cycle/stall counters are built when GPPCU_PIPE_PERF_EN is defined.
module gppcu_pipe_ctrl #(
    parameter int         DBW      = 32,
    parameter int         IABW     = 10,
    parameter int         CW_BITS  = 16,
    parameter int         OPC_LSB  = 26,
    parameter logic [5:0] HALT_OPC = 6'h3F
) (
    input  logic                iACLK,
    input  logic                iARESETn,
    input  logic                iSTART,
    input  logic [IABW-1:0]     iSTART_PC,
    output logic                oIDLE,
    output logic                oDONE,
    output logic [IABW-1:0]     oIMEM_ADDR,
    output logic                oIMEM_RDEN,
    input  logic [DBW-1:0]      iIMEM_RDATA,
    output logic [DBW-1:0]      oDEC_INSTR,
    input  logic [CW_BITS-1:0]  iDEC_CW,
    input  logic                iBUSY,
    output logic [DBW-1:0]      oINSTR_FCH,
    output logic [DBW-1:0]      oINSTR_DEC,
    output logic [DBW-1:0]      oINSTR_EXEC,
    output logic [DBW-1:0]      oINSTR_WB,
    output logic [CW_BITS-1:0]  oCW_DEC,
    output logic [CW_BITS-1:0]  oCW_EXEC,
    output logic [CW_BITS-1:0]  oCW_WB
`ifdef GPPCU_PIPE_PERF_EN
    ,
    output logic [31:0]         oPERF_CYCLES,
    output logic [31:0]         oPERF_STALLS
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [IABW-1:0]     pc;
    logic                idle_q;
    logic                done_q;

    logic                adv;
    logic                halt_p1;
    logic                rden;

    logic                vld_p0;
    logic [DBW-1:0]      instr_p0;
    logic                vld_p1;
    logic [DBW-1:0]      instr_p1;
    logic [CW_BITS-1:0]  cw_p1;
    logic [DBW-1:0]      instr_p2;
    logic [CW_BITS-1:0]  cw_p2;
    logic [DBW-1:0]      instr_p3;
    logic [CW_BITS-1:0]  cw_p3;

    assign adv     = !iBUSY;
    assign halt_p1 = vld_p1 && (instr_p1[OPC_LSB +: 6] == HALT_OPC);
    // A HALT advancing out of DEC also suppresses the read that would follow it.
    assign rden    = (state == S_RUN) && adv && !halt_p1;

    // FCH is the memory read port itself: rdata stays put while no read is enabled.
    assign instr_p0 = vld_p0 ? iIMEM_RDATA : '0;
    assign cw_p1    = vld_p1 ? (iDEC_CW | CW_BITS'(1)) : '0;

    always_ff @(posedge iACLK) begin
        if (!iARESETn) begin
            state  <= S_IDLE;
            pc     <= '0;
            idle_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iSTART) begin
                        pc     <= iSTART_PC;
                        idle_q <= 1'b0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rden)
                        pc <= pc + IABW'(1);
                    if (adv && halt_p1)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!cw_p2[0] && !cw_p3[0]) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    idle_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    idle_q <= 1'b1;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iACLK) begin
        if (!iARESETn) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            instr_p2 <= '0;
            cw_p2    <= '0;
            instr_p3 <= '0;
            cw_p3    <= '0;
        end else if (adv) begin
            // p0 -> p1: the fetch behind a HALT is squashed
            vld_p0   <= rden;
            vld_p1   <= vld_p0 && !halt_p1;
            instr_p1 <= instr_p0;
            // p1 -> p2: HALT becomes a bubble
            instr_p2 <= instr_p1;
            cw_p2    <= halt_p1 ? '0 : cw_p1;
            // p2 -> p3
            instr_p3 <= instr_p2;
            cw_p3    <= cw_p2;
        end else begin
            cw_p3[0] <= 1'b0;
        end
    end

`ifdef GPPCU_PIPE_PERF_EN
    logic [31:0] perf_cyc;
    logic [31:0] perf_stl;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge iACLK) begin
        if (!iARESETn) begin
            perf_cyc <= '0;
            perf_stl <= '0;
        end else if (state == S_IDLE && iSTART) begin
            perf_cyc <= '0;
            perf_stl <= '0;
        end else if (state == S_RUN || state == S_DRAIN) begin
            perf_cyc <= sat_inc(perf_cyc);
            if (iBUSY)
                perf_stl <= sat_inc(perf_stl);
        end
    end

    assign oPERF_CYCLES = perf_cyc;
    assign oPERF_STALLS = perf_stl;
`endif

    assign oIDLE       = idle_q;
    assign oDONE       = done_q;
    assign oIMEM_ADDR  = pc;
    assign oIMEM_RDEN  = rden;
    assign oDEC_INSTR  = instr_p1;
    assign oINSTR_FCH  = instr_p0;
    assign oINSTR_DEC  = instr_p1;
    assign oINSTR_EXEC = instr_p2;
    assign oINSTR_WB   = instr_p3;
    assign oCW_DEC     = cw_p1;
    assign oCW_EXEC    = cw_p2;
    assign oCW_WB      = cw_p3;

endmodule

// File: tb/tb_gppcu_pipe_ctrl.sv
// Bench for gppcu_pipe_ctrl: kernel vector table, WB scoreboard, reset sequences.
module tb_gppcu_pipe_ctrl;

    localparam int DBW = 32;
    localparam int IABW = 10;
    localparam int CW_BITS = 16;

    logic                iACLK = 1'b0;
    logic                iARESETn;
    logic                iSTART;
    logic [IABW-1:0]     iSTART_PC;
    logic                oIDLE;
    logic                oDONE;
    logic [IABW-1:0]     oIMEM_ADDR;
    logic                oIMEM_RDEN;
    logic [DBW-1:0]      iIMEM_RDATA;
    logic [DBW-1:0]      oDEC_INSTR;
    logic [CW_BITS-1:0]  iDEC_CW;
    logic                iBUSY;
    logic [DBW-1:0]      oINSTR_FCH, oINSTR_DEC, oINSTR_EXEC, oINSTR_WB;
    logic [CW_BITS-1:0]  oCW_DEC, oCW_EXEC, oCW_WB;
`ifdef GPPCU_PIPE_PERF_EN
    logic [31:0]         oPERF_CYCLES, oPERF_STALLS;
`endif

    always #5 iACLK = ~iACLK;

    gppcu_pipe_ctrl dut (
        .iACLK       (iACLK),
        .iARESETn    (iARESETn),
        .iSTART      (iSTART),
        .iSTART_PC   (iSTART_PC),
        .oIDLE       (oIDLE),
        .oDONE       (oDONE),
        .oIMEM_ADDR  (oIMEM_ADDR),
        .oIMEM_RDEN  (oIMEM_RDEN),
        .iIMEM_RDATA (iIMEM_RDATA),
        .oDEC_INSTR  (oDEC_INSTR),
        .iDEC_CW     (iDEC_CW),
        .iBUSY       (iBUSY),
        .oINSTR_FCH  (oINSTR_FCH),
        .oINSTR_DEC  (oINSTR_DEC),
        .oINSTR_EXEC (oINSTR_EXEC),
        .oINSTR_WB   (oINSTR_WB),
        .oCW_DEC     (oCW_DEC),
        .oCW_EXEC    (oCW_EXEC),
        .oCW_WB      (oCW_WB)
`ifdef GPPCU_PIPE_PERF_EN
        ,
        .oPERF_CYCLES(oPERF_CYCLES),
        .oPERF_STALLS(oPERF_STALLS)
`endif
    );

    // Instruction memory: one-cycle registered read, data held when not enabled.
    logic [DBW-1:0] mem [0:(1<<IABW)-1];
    logic [DBW-1:0] rdata_q = '0;
    always @(posedge iACLK) if (oIMEM_RDEN) rdata_q <= mem[oIMEM_ADDR];
    assign iIMEM_RDATA = rdata_q;

    function automatic logic [CW_BITS-1:0] dec_model(input logic [DBW-1:0] ins);
        return {ins[31:26], ins[9:0]};
    endfunction
    assign iDEC_CW = dec_model(oDEC_INSTR);

    function automatic logic [DBW-1:0] nop_word(input logic [IABW-1:0] a);
        logic [15:0] tag;
        tag = 16'hA500 ^ {6'd0, a};
        return {6'h00, tag, a};
    endfunction

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [IABW-1:0] start_pc;
        int              bs;
        int              bl;
        int              pulse_t;
        int              exp_done;
        logic [DBW-1:0]  exp_hold;
    } vec_t;

    vec_t vecs [4];
    logic [DBW-1:0] sb [$];

    task automatic run_vec(input vec_t v);
        logic [IABW-1:0] a, ha, off, span;
        logic [DBW-1:0]  ins;
        logic [CW_BITS-1:0] ecw;
        logic [IABW-1:0] eaddr;
        int done_t;
        sb.delete();
        a = v.start_pc;
        for (int k = 0; k < (1<<IABW); k++) begin
            if (mem[a][31:26] == 6'h3F) break;
            sb.push_back(mem[a]);
            a = a + 1'b1;
        end
        ha = a;
        @(negedge iACLK);
        iSTART = 1'b1;
        iSTART_PC = v.start_pc;
        iBUSY = 1'b0;
        done_t = -1;
        for (int t = 1; t <= 60 && done_t < 0; t++) begin
            @(negedge iACLK);
            iSTART = (t == v.pulse_t);
            iSTART_PC = (t == v.pulse_t) ? 10'h100 : v.start_pc;
            iBUSY = (v.bl > 0 && t >= v.bs && t < v.bs + v.bl);
            #1;
            if (t <= 3) begin
                eaddr = v.start_pc + IABW'(t - 1);
                check("imem_addr", 32'(oIMEM_ADDR), 32'(eaddr));
            end
            if (t == 1) check("rden_t1", 32'(oIMEM_RDEN), 32'd1);
            if (iBUSY) check("rden_stall", 32'(oIMEM_RDEN), 32'd0);
            if (v.bl > 0 && t >= v.bs && t < v.bs + v.bl)
                check("exec_hold", oINSTR_EXEC, v.exp_hold);
            if (v.bl > 0 && t > v.bs && t <= v.bs + v.bl)
                check("wb_bubble", 32'(oCW_WB[0]), 32'd0);
            if (oCW_DEC[0]) begin
                off = oINSTR_DEC[IABW-1:0] - v.start_pc;
                span = ha - v.start_pc;
                check("dec_range", 32'(off <= span), 32'd1);
            end
            if (oCW_WB[0]) begin
                if (sb.size() == 0) begin
                    check("wb_extra", oINSTR_WB, 32'hFFFF_FFFF);
                end else begin
                    ins = sb.pop_front();
                    ecw = dec_model(ins);
                    ecw[0] = 1'b1;
                    check("wb_instr", oINSTR_WB, ins);
                    check("wb_cw", 32'(oCW_WB), 32'(ecw));
                end
            end
            if (oDONE) done_t = t;
        end
        iBUSY = 1'b0;
        iSTART = 1'b0;
        check("done_cycle", 32'(done_t), 32'(v.exp_done));
        check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef GPPCU_PIPE_PERF_EN
        check("perf_cycles", oPERF_CYCLES, 32'(v.exp_done - 1));
        check("perf_stalls", oPERF_STALLS, 32'(v.bl));
`endif
        @(negedge iACLK);
        #1;
        check("idle_after", 32'(oIDLE), 32'd1);
        check("done_pulse", 32'(oDONE), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1<<IABW); i++) mem[i] = nop_word(IABW'(i));
        mem[10'h000] = {6'h3F, 16'h0000, 10'h000};
        mem[10'h013] = {6'h3F, 16'h0000, 10'h013};

        vecs[0] = '{start_pc: 10'h000, bs: 0, bl: 0, pulse_t: 0, exp_done: 5,  exp_hold: '0};
        vecs[1] = '{start_pc: 10'h010, bs: 0, bl: 0, pulse_t: 0, exp_done: 9,  exp_hold: '0};
        vecs[2] = '{start_pc: 10'h010, bs: 5, bl: 4, pulse_t: 0, exp_done: 13, exp_hold: nop_word(10'h011)};
        vecs[3] = '{start_pc: 10'h3FF, bs: 0, bl: 0, pulse_t: 2, exp_done: 7,  exp_hold: '0};

        iARESETn = 1'b0;
        iSTART = 1'b1;
        iSTART_PC = 10'h005;
        iBUSY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iACLK);
            #1;
            check("rst_idle", 32'(oIDLE), 32'd1);
            check("rst_valids", {29'd0, oCW_DEC[0], oCW_EXEC[0], oCW_WB[0]}, 32'd0);
            check("rst_rden", 32'(oIMEM_RDEN), 32'd0);
            check("rst_done", 32'(oDONE), 32'd0);
            check("rst_wb", {oINSTR_WB[15:0], oCW_WB}, 32'd0);
        end
        @(negedge iACLK);
        iARESETn = 1'b1;
        iSTART = 1'b0;
        #1;
        check("rst_addr", 32'(oIMEM_ADDR), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset in the middle of a kernel: no done pulse, pipeline emptied.
        @(negedge iACLK);
        iSTART = 1'b1;
        iSTART_PC = 10'h010;
        for (int t = 1; t <= 4; t++) begin
            @(negedge iACLK);
            iSTART = 1'b0;
        end
        iARESETn = 1'b0;
        @(negedge iACLK);
        iARESETn = 1'b1;
        #1;
        check("abort_idle", 32'(oIDLE), 32'd1);
        check("abort_valids", {29'd0, oCW_DEC[0], oCW_EXEC[0], oCW_WB[0]}, 32'd0);
        check("abort_rden", 32'(oIMEM_RDEN), 32'd0);
        for (int t = 0; t < 10; t++) begin
            @(negedge iACLK);
            #1;
            check("abort_no_done", {30'd0, oDONE, oCW_WB[0]}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
